// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encodings, oversampling constants and the baud divider helper
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4;
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_v3_if.sv
// uart_v3_if: core-side transmit/receive word handshake of uart_v3
interface uart_v3_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data, rx_data;
  logic tx_valid, tx_ready, rx_valid, rx_frame_err, rx_parity_err;
  modport master(output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err);
  modport slave(input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversample tick divider with a clearable 4-bit bit-phase counter
module uart_baud_tick #(parameter int DIV = 1) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  output logic       tick_o,
  output logic [3:0] phase_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0] phase_q, phase_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  assign phase_o = phase_q;
  always_comb begin
    cnt_d = clr_i || tick_o ? '0 : cnt_q + 1'b1;
    phase_d = clr_i ? '0 : tick_o ? phase_q + 4'd1 : phase_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      phase_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/uart_v3.sv
// uart_v3: full-duplex UART with independent TX/RX engines and 16x oversampled RX.
// Define UART_PARITY_EN to add a parity bit (sense set by PARITY_ODD) to every frame.
module uart_v3 import uart_pkg::*; #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic      CLK50M,
  input  logic      RST,
  input  logic      RX,
  output logic      TX,
  uart_v3_if.slave  bus
);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam logic [2:0] AFTER_DATA = PAR_EN ? S_PARITY : S_STOP;
  localparam logic [3:0] LAST_PH = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_PH = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic PAR_SENSE = 1'(PARITY_ODD);

  if (DIV < 1) begin : g_bad_div
    $error("uart_v3: CLK_HZ/(BAUD*16) must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
    $error("uart_v3: DATA_BITS must be 5..9 and STOP_BITS 1 or 2");
  end

  logic tx_tick, tx_acc, tx_end;
  logic [3:0] tx_ph;
  logic [2:0] tx_st_q, tx_st_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic tx_stop_q, tx_stop_d, tx_par_q, tx_par_d;

  assign tx_acc = bus.tx_valid && tx_st_q == S_IDLE;
  assign tx_end = tx_tick && tx_ph == LAST_PH;

  // Accepting a word restarts the TX bit phase so the start bit gets a full 16 ticks
  uart_baud_tick #(.DIV(DIV)) u_tx_tick (
    .clk(CLK50M), .rst(RST), .clr_i(tx_acc), .tick_o(tx_tick), .phase_o(tx_ph)
  );

  always_comb begin
    tx_st_d = tx_st_q;
    tx_sh_d = tx_sh_q;
    tx_bit_d = tx_bit_q;
    tx_stop_d = tx_stop_q;
    tx_par_d = tx_par_q;
    case (tx_st_q)
      S_IDLE: if (tx_acc) begin
        tx_st_d = S_START;
        tx_sh_d = bus.tx_data;
        tx_par_d = ^bus.tx_data ^ PAR_SENSE;
        tx_bit_d = '0;
        tx_stop_d = 1'b0;
      end
      S_START: if (tx_end) tx_st_d = S_DATA;
      S_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 4'd1;
        if (tx_bit_q == LAST_BIT) tx_st_d = AFTER_DATA;
      end
      S_PARITY: if (tx_end) tx_st_d = S_STOP;
      S_STOP: if (tx_end) begin
        tx_stop_d = 1'b1;
        if (tx_stop_q == 1'(STOP_BITS - 1)) tx_st_d = S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  assign bus.tx_ready = tx_st_q == S_IDLE;
  assign TX = tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] :
              tx_st_q == S_PARITY ? tx_par_q : 1'b1;

  logic rx_s1_q, rx_s2_q;
  logic rx_tick, rx_mid, rx_samp, rx_clr;
  logic [3:0] rx_ph;
  logic [2:0] rx_st_q, rx_st_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [3:0] rx_bit_q, rx_bit_d;
  logic rx_par_q, rx_par_d, rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d, rx_perr_q, rx_perr_d;

  assign rx_mid = rx_tick && rx_ph == MID_PH;
  assign rx_samp = rx_tick && rx_ph == LAST_PH;
  // Phase restarts at the start edge, then again at start mid-bit so data samples land mid-bit
  assign rx_clr = !rx_s2_q && ((rx_st_q == S_IDLE && rx_tick) || (rx_st_q == S_START && rx_mid));

  uart_baud_tick #(.DIV(DIV)) u_rx_tick (
    .clk(CLK50M), .rst(RST), .clr_i(rx_clr), .tick_o(rx_tick), .phase_o(rx_ph)
  );

  always_comb begin
    rx_st_d = rx_st_q;
    rx_sh_d = rx_sh_q;
    rx_bit_d = rx_bit_q;
    rx_par_d = rx_par_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    rx_ferr_d = 1'b0;
    rx_perr_d = 1'b0;
    case (rx_st_q)
      S_IDLE: if (rx_tick && !rx_s2_q) rx_st_d = S_START;
      S_START: if (rx_mid) begin
        rx_st_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_bit_d = '0;
      end
      S_DATA: if (rx_samp) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 4'd1;
        if (rx_bit_q == LAST_BIT) rx_st_d = AFTER_DATA;
      end
      S_PARITY: if (rx_samp) begin
        rx_par_d = rx_s2_q;
        rx_st_d = S_STOP;
      end
      S_STOP: if (rx_samp) begin
        rx_st_d = S_IDLE;
        rx_data_d = rx_sh_q;
        rx_valid_d = 1'b1;
        rx_ferr_d = !rx_s2_q;
        rx_perr_d = PAR_EN && (rx_par_q != (^rx_sh_q ^ PAR_SENSE));
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_frame_err = rx_ferr_q;
  assign bus.rx_parity_err = rx_perr_q;

  always_ff @(posedge CLK50M) begin
    if (RST) begin
      tx_st_q <= S_IDLE;
      tx_sh_q <= '0;
      tx_bit_q <= '0;
      tx_stop_q <= 1'b0;
      tx_par_q <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_st_q <= S_IDLE;
      rx_sh_q <= '0;
      rx_bit_q <= '0;
      rx_par_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_sh_q <= tx_sh_d;
      tx_bit_q <= tx_bit_d;
      tx_stop_q <= tx_stop_d;
      tx_par_q <= tx_par_d;
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      rx_st_q <= rx_st_d;
      rx_sh_q <= rx_sh_d;
      rx_bit_q <= rx_bit_d;
      rx_par_q <= rx_par_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q <= rx_ferr_d;
      rx_perr_q <= rx_perr_d;
    end
  end
endmodule

// File: tb/tb_uart_v3.sv
// tb_uart_v3: scoreboard bench for uart_v3; TX frames decoded from the line, RX words checked on strobe
module tb_uart_v3;
  localparam int DB = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME = 176;
`else
  localparam int FRAME = 160;
`endif
  typedef struct packed { logic [DB-1:0] d; logic fe; logic pe; } rx_t;

  logic clk = 1'b0, rst = 1'b1, rx_drv = 1'b1, loop = 1'b0;
  logic tx, rx_line;
  int n_chk = 0, n_fail = 0;
  rx_t rx_q[$];
  logic [DB-1:0] tx_q[$];

  uart_v3_if #(.DATA_BITS(DB)) bus ();
  assign rx_line = loop ? tx : rx_drv;

  uart_v3 #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(DB), .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .CLK50M(clk), .RST(rst), .RX(rx_line), .TX(tx), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic skip(input int n, inout logic ab);
    repeat (n) begin
      @(negedge clk);
      ab = ab | rst;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (bus.tx_ready !== 1'b1 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check("tx_ready_timeout", bus.tx_ready, 1);
  endtask

  task automatic send(input logic [DB-1:0] w, input bit exp_tx, input bit exp_rx);
    wait_ready();
    bus.tx_valid = 1'b1;
    bus.tx_data = w;
    if (exp_tx) tx_q.push_back(w);
    if (exp_rx) rx_q.push_back(rx_t'{d: w, fe: 1'b0, pe: 1'b0});
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input logic [DB-1:0] w, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(w[i]);
`ifdef UART_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    rx_drv = 1'b1;
  endtask

  always @(negedge clk) begin : rx_mon
    rx_t e;
    if (!rst) begin
      if (bus.rx_valid === 1'b1) begin
        if (rx_q.size() == 0) check("rx_unexpected_strobe", rx_q.size(), 1);
        else begin
          e = rx_q.pop_front();
          check("rx_data", bus.rx_data, e.d);
          check("rx_frame_err", bus.rx_frame_err, e.fe);
          check("rx_parity_err", bus.rx_parity_err, e.pe);
        end
      end else check("rx_err_without_valid", {bus.rx_frame_err, bus.rx_parity_err}, 2'b00);
    end
  end

  initial begin : tx_mon
    logic [DB-1:0] w, e;
    logic st, sb, pb, ab;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        ab = 1'b0;
        pb = 1'b0;
        skip(8, ab);
        st = tx;
        for (int i = 0; i < DB; i++) begin
          skip(16, ab);
          w[i] = tx;
        end
`ifdef UART_PARITY_EN
        skip(16, ab);
        pb = tx;
`endif
        skip(16, ab);
        sb = tx;
        if (!ab) begin
          if (tx_q.size() == 0) check("tx_unexpected_frame", tx_q.size(), 1);
          else begin
            e = tx_q.pop_front();
            check("tx_start_bit", st, 0);
            check("tx_data_bits", w, e);
            check("tx_stop_bit", sb, 1);
`ifdef UART_PARITY_EN
            check("tx_parity_bit", pb, ^e);
`endif
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, highs, first;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_tx_ready", bus.tx_ready, 1);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_frame_err", bus.rx_frame_err, 0);
    check("reset_parity_err", bus.rx_parity_err, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    loop = 1'b1;
    send(8'hA5, 1'b1, 1'b1);
    check("tx_ready_drop", bus.tx_ready, 0);
    k = 0;
    while (bus.tx_ready !== 1'b1 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("tx_ready_latency", k, FRAME);
    repeat (20) @(posedge clk);
    #1;
    check("loopback_drained", rx_q.size(), 0);

    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rx_q.push_back(rx_t'{d: 8'h3C, fe: 1'b0, pe: 1'b0});
    drive_rx(8'h3C, 1'b0, 1'b1);
    repeat (24) @(posedge clk);
    #1;

    rx_q.push_back(rx_t'{d: 8'h55, fe: 1'b1, pe: 1'b0});
    drive_rx(8'h55, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;

    loop = 1'b1;
    wait_ready();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h01;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h80);
    rx_q.push_back(rx_t'{d: 8'h01, fe: 1'b0, pe: 1'b0});
    rx_q.push_back(rx_t'{d: 8'h80, fe: 1'b0, pe: 1'b0});
    @(posedge clk); #1;
    bus.tx_data = 8'h80;
    highs = 0;
    first = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (bus.tx_ready) begin
        highs++;
        if (first == 0) first = i;
      end
      if (i == FRAME + 1) bus.tx_valid = 1'b0;
    end
    check("b2b_first_ready", first, FRAME);
    check("b2b_ready_cycles", highs, 1);
    @(posedge clk); #1;
    check("b2b_ready_after_second", bus.tx_ready, 1);
    repeat (24) @(posedge clk);
    #1;

`ifdef UART_PARITY_EN
    loop = 1'b0;
    send(8'h03, 1'b1, 1'b0);
    wait_ready();
    repeat (8) @(posedge clk);
    #1;
    rx_q.push_back(rx_t'{d: 8'h03, fe: 1'b0, pe: 1'b1});
    drive_rx(8'h03, 1'b1, 1'b1);
    rx_q.push_back(rx_t'{d: 8'h03, fe: 1'b0, pe: 1'b0});
    drive_rx(8'h03, 1'b0, 1'b1);
    repeat (24) @(posedge clk);
    #1;
`endif

    loop = 1'b0;
    send(8'h0F, 1'b0, 1'b0);
    repeat (87) @(posedge clk);
    #1;
    check("tx_bit4_before_reset", tx, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx_high", tx, 1);
    check("abort_tx_ready", bus.tx_ready, 1);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    loop = 1'b1;
    send(8'hFF, 1'b1, 1'b1);
    wait_ready();
    repeat (200) @(posedge clk);
    #1;
    check("tx_queue_drained", tx_q.size(), 0);
    check("rx_queue_drained", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
